vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator that replaces the fixed 640x480 sync logic in the FlappyBird top level. It divides the system clock down to a pixel strobe and runs horizontal and vertical counters from configurable porch and sync widths. It exposes the current pixel coordinate to the game renderer, registers the renderer's colour, and drives blanked `rgb`, `hSync` and `vSync` to the connector. Polarity, resolution, colour width and clock divide are all parameters.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/pix_strobe_div.sv | 27 ++
 rtl/vga_timing_gen.sv | 95 +++++++++
 tb/tb_vga_timing_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default 640x480@60 timing constants and raster helpers
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CLK_DIV  = 4;

    function automatic int raster_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Sync window is inclusive on both ends: [active+fp, active+fp+sync-1].
    function automatic int sync_first(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int sync_last(input int active, input int fp, input int sync);
        return active + fp + sync - 1;
    endfunction

endpackage

// File: rtl/pix_strobe_div.sv
// rtl/pix_strobe_div.sv - divides clk down to a one-clk pixel strobe
module pix_strobe_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic pix_tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            div <= '0;
        end else if (en) begin
            div <= (div == LAST) ? '0 : div + DW'(1);
        end
    end

    // Gating with clr keeps the strobe low in reset even when CLK_DIV is 1.
    assign pix_tick = en && clr && (div == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster counters, sync and blanked colour
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int RGB_W    = 8,
    parameter int X_W      = 10,
    parameter int Y_W      = 10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [RGB_W-1:0] rgb_in,
    output logic [X_W-1:0]   pix_x,
    output logic [Y_W-1:0]   pix_y,
    output logic             pix_valid,
    output logic             pix_tick,
    output logic             frame_start,
    output logic             hSync,
    output logic             vSync,
    output logic [RGB_W-1:0] rgb
);

    localparam int H_TOTAL = raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [X_W-1:0] H_LAST  = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] V_LAST  = Y_W'(V_TOTAL - 1);
    localparam logic [X_W-1:0] H_ACT   = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0] V_ACT   = Y_W'(V_ACTIVE);
    localparam logic [X_W-1:0] HS_LO   = X_W'(sync_first(H_ACTIVE, H_FP));
    localparam logic [X_W-1:0] HS_HI   = X_W'(sync_last(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [Y_W-1:0] VS_LO   = Y_W'(sync_first(V_ACTIVE, V_FP));
    localparam logic [Y_W-1:0] VS_HI   = Y_W'(sync_last(V_ACTIVE, V_FP, V_SYNC));

    logic [X_W-1:0] h_cnt;
    logic [Y_W-1:0] v_cnt;
    logic           hs_raw;
    logic           vs_raw;

    pix_strobe_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk      (clk),
        .clr      (clr),
        .en       (en),
        .pix_tick (pix_tick)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + Y_W'(1);
            end else begin
                h_cnt <= h_cnt + X_W'(1);
            end
        end
    end

    assign pix_x       = h_cnt;
    assign pix_y       = v_cnt;
    assign pix_valid   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign frame_start = pix_tick && (h_cnt == '0) && (v_cnt == '0);

    assign hs_raw = (h_cnt >= HS_LO) && (h_cnt <= HS_HI);
    assign vs_raw = (v_cnt >= VS_LO) && (v_cnt <= VS_HI);

    // Sync and colour register on the same tick so they stay aligned one pixel behind the counters.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hSync <= ~H_POL;
            vSync <= ~V_POL;
            rgb   <= '0;
        end else if (pix_tick) begin
            hSync <= H_POL ? hs_raw : ~hs_raw;
            vSync <= V_POL ? vs_raw : ~vs_raw;
            rgb   <= pix_valid ? rgb_in : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen on a 7x6 raster
module tb_vga_timing_gen;

    localparam int CLK_DIV = 3;

    typedef struct {
        logic [2:0] x;
        logic [2:0] y;
        logic       fs;
        logic       hs;
        logic       vs;
        logic [7:0] rgb;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       en  = 1'b1;
    logic [7:0] rgb_in;
    logic [2:0] pix_x;
    logic [2:0] pix_y;
    logic       pix_valid;
    logic       pix_tick;
    logic       frame_start;
    logic       hSync;
    logic       vSync;
    logic [7:0] rgb;

    int   checks = 0;
    int   fails  = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];

    always #5 clk = ~clk;

    assign rgb_in = {2'b00, pix_y, pix_x};

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .CLK_DIV  (CLK_DIV),
        .H_POL    (1'b1), .V_POL (1'b0),
        .RGB_W    (8), .X_W (3), .Y_W (3)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .en          (en),
        .rgb_in      (rgb_in),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_valid   (pix_valid),
        .pix_tick    (pix_tick),
        .frame_start (frame_start),
        .hSync       (hSync),
        .vSync       (vSync),
        .rgb         (rgb)
    );

    // Each entry: counter state seen at a tick, plus stage-1 outputs of the previous pixel.
    task automatic push_frames(input int nframes);
        logic       hs_p  = 1'b0;
        logic       vs_p  = 1'b1;
        logic [7:0] rgb_p = 8'h00;
        exp_t       e;
        for (int f = 0; f < nframes; f++) begin
            for (int y = 0; y < 6; y++) begin
                for (int x = 0; x < 7; x++) begin
                    e.x   = 3'(x);
                    e.y   = 3'(y);
                    e.fs  = (x == 0) && (y == 0);
                    e.hs  = hs_p;
                    e.vs  = vs_p;
                    e.rgb = rgb_p;
                    q.push_back(e);
                    hs_p  = (x == 5);
                    vs_p  = (y != 4);
                    rgb_p = (x < 4 && y < 3) ? {2'b00, 3'(y), 3'(x)} : 8'h00;
                end
            end
        end
    endtask

    task automatic check_reset_state(input string name);
        checks++;
        if (pix_x !== 3'd0 || pix_y !== 3'd0 || pix_tick !== 1'b0 || frame_start !== 1'b0 ||
            hSync !== 1'b0 || vSync !== 1'b1 || rgb !== 8'h00) begin
            fails++;
            $display("FAIL %s: got x=%0d y=%0d tick=%b fs=%b hs=%b vs=%b rgb=%h, want 0 0 0 0 0 1 00",
                     name, pix_x, pix_y, pix_tick, frame_start, hSync, vSync, rgb);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d expected ticks never arrived, want 0 left", name, q.size());
        end
    endtask

    task automatic wait_pos(input logic [2:0] x, input logic [2:0] y, input string name);
        int n = 0;
        while (!(pix_x == x && pix_y == y) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!(pix_x == x && pix_y == y)) begin
            fails++;
            $display("FAIL %s: at x=%0d y=%0d, want x=%0d y=%0d", name, pix_x, pix_y, x, y);
        end
    endtask

    // Monitor: tick spacing must equal CLK_DIV plus any en-low cycles in between.
    int cyc = 0;
    int prev_cyc = 0;
    int lowcnt = 0;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!clr) begin
            prev_cyc = cyc;
            lowcnt   = 0;
        end else begin
            if (!en) lowcnt++;
            if (pix_tick) begin
                if (mon_en) begin
                    checks++;
                    if (cyc - prev_cyc != CLK_DIV + lowcnt) begin
                        fails++;
                        $display("FAIL tick_gap: got %0d clk, want %0d", cyc - prev_cyc, CLK_DIV + lowcnt);
                    end
                    checks++;
                    if (q.size() == 0) begin
                        fails++;
                        $display("FAIL tick_extra: got tick at x=%0d y=%0d, want none", pix_x, pix_y);
                    end else begin
                        e = q.pop_front();
                        if (pix_x !== e.x || pix_y !== e.y || frame_start !== e.fs ||
                            hSync !== e.hs || vSync !== e.vs || rgb !== e.rgb) begin
                            fails++;
                            $display("FAIL tick_out: got x=%0d y=%0d fs=%b hs=%b vs=%b rgb=%h, want x=%0d y=%0d fs=%b hs=%b vs=%b rgb=%h",
                                     pix_x, pix_y, frame_start, hSync, vSync, rgb,
                                     e.x, e.y, e.fs, e.hs, e.vs, e.rgb);
                        end
                    end
                end
                prev_cyc = cyc;
                lowcnt   = 0;
            end
        end
    end

    initial begin
        logic [2:0] sx;
        logic [2:0] sy;
        logic       shs;
        logic       svs;
        logic [7:0] srgb;

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset_initial");

        push_frames(3);
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b1;

        // Drop en for 10 clk one cycle into a pixel period.
        wait_pos(3'd2, 3'd1, "reach_en_drop");
        @(posedge clk);
        #1;
        en   = 1'b0;
        sx   = pix_x;
        sy   = pix_y;
        shs  = hSync;
        svs  = vSync;
        srgb = rgb;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (pix_x !== sx || pix_y !== sy || hSync !== shs || vSync !== svs || rgb !== srgb ||
                pix_tick !== 1'b0 || frame_start !== 1'b0) begin
                fails++;
                $display("FAIL en_freeze: got x=%0d y=%0d hs=%b vs=%b rgb=%h tick=%b, want x=%0d y=%0d hs=%b vs=%b rgb=%h tick=0",
                         pix_x, pix_y, hSync, vSync, rgb, pix_tick, sx, sy, shs, svs, srgb);
            end
        end
        @(posedge clk);
        #1;
        en = 1'b1;
        wait_drain("drain_run");

        // Mid-frame reset while both syncs are active.
        mon_en = 1'b0;
        wait_pos(3'd6, 3'd4, "reach_reset_point");
        checks++;
        if (hSync !== 1'b1 || vSync !== 1'b0) begin
            fails++;
            $display("FAIL sync_active_pre_reset: got hs=%b vs=%b, want hs=1 vs=0", hSync, vSync);
        end
        clr = 1'b0;
        #1;
        check_reset_state("reset_midframe");
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset_held");
        q.delete();
        push_frames(1);
        mon_en = 1'b1;
        clr    = 1'b1;
        wait_drain("drain_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
